// File: rtl/cacheline_adaptor.sv
// cacheline_adaptor
//
// Bridges the single-transfer cache line port of the L2 cache to a burst
// DRAM port. A line read is assembled from s_line/s_burst consecutive beats;
// a dirty-line writeback is split into the same number of beats.
//
// Ports:
//   clk        clock, rising edge
//   rst        asynchronous, active-high reset
//   line_i     writeback line from the cache
//   line_o     assembled read line to the cache (holds until next refill)
//   address_i  line address from the cache
//   read_i     line read request
//   write_i    line write request (wins over read_i when both are high)
//   resp_o     one-cycle completion pulse to the cache
//   burst_i    read beat from DRAM
//   burst_o    write beat to DRAM
//   address_o  line-aligned burst address, constant for the whole burst
//   read_o     burst read request
//   write_o    burst write request
//   resp_i     DRAM beat strobe: read beat valid / write beat accepted
//
// All DRAM-side and completion outputs are decoded from registered state,
// so there is no combinational path from any input to any output.

module cacheline_adaptor #(
  parameter int s_line  = 256,
  parameter int s_burst = 64
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [s_line-1:0]  line_i,
  output logic [s_line-1:0]  line_o,
  input  logic [31:0]        address_i,
  input  logic               read_i,
  input  logic               write_i,
  output logic               resp_o,
  input  logic [s_burst-1:0] burst_i,
  output logic [s_burst-1:0] burst_o,
  output logic [31:0]        address_o,
  output logic               read_o,
  output logic               write_o,
  input  logic               resp_i
);

  localparam int beats = s_line / s_burst;
  localparam int cnt_w = (beats > 1) ? $clog2(beats) : 1;
  // Byte offset within a line; these address bits are forced to zero.
  localparam int off_w = $clog2(s_line / 8);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RD   = 2'd1,
    WR   = 2'd2,
    DONE = 2'd3
  } state_t;

  state_t              state_reg, state_next;
  logic [cnt_w-1:0]    count_reg, count_next;
  logic [s_line-1:0]   wline_reg, wline_next;
  logic [s_line-1:0]   rline_reg, rline_next;
  logic [31:0]         addr_reg, addr_next;
  logic                last_beat;

  // The byte-offset bits of the incoming address are deliberately dropped.
  logic                unused_addr_bits;
  assign unused_addr_bits = ^address_i[off_w-1:0];

  assign last_beat = (count_reg == cnt_w'(beats - 1));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg <= IDLE;
      count_reg <= '0;
      wline_reg <= '0;
      rline_reg <= '0;
      addr_reg  <= '0;
    end else begin
      state_reg <= state_next;
      count_reg <= count_next;
      wline_reg <= wline_next;
      rline_reg <= rline_next;
      addr_reg  <= addr_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    count_next = count_reg;
    wline_next = wline_reg;
    rline_next = rline_reg;
    addr_next  = addr_reg;

    case (state_reg)
      IDLE: begin
        if (write_i) begin
          wline_next = line_i;
          addr_next  = {address_i[31:off_w], {off_w{1'b0}}};
          count_next = '0;
          state_next = WR;
        end else if (read_i) begin
          addr_next  = {address_i[31:off_w], {off_w{1'b0}}};
          count_next = '0;
          state_next = RD;
        end
      end

      RD: begin
        if (resp_i) begin
          rline_next[s_burst*count_reg +: s_burst] = burst_i;
          // Counter wraps back to zero on the final beat.
          count_next = count_reg + cnt_w'(1);
          if (last_beat) begin
            state_next = DONE;
          end
        end
      end

      WR: begin
        if (resp_i) begin
          count_next = count_reg + cnt_w'(1);
          if (last_beat) begin
            state_next = DONE;
          end
        end
      end

      DONE: begin
        state_next = IDLE;
      end

      default: begin
        state_next = IDLE;
      end
    endcase
  end

  assign read_o    = (state_reg == RD);
  assign write_o   = (state_reg == WR);
  assign resp_o    = (state_reg == DONE);
  assign address_o = addr_reg;
  assign line_o    = rline_reg;
  // Only present a beat while a write burst is actually in progress.
  assign burst_o   = (state_reg == WR) ? wline_reg[s_burst*count_reg +: s_burst]
                                       : '0;

endmodule

// File: tb/tb_cacheline_adaptor.sv
// Self-checking bench for cacheline_adaptor. Inputs are driven and outputs
// sampled on the falling clock edge. Expected values come from a
// transaction-level model: the line a refill should produce is the
// concatenation of the beats the bench handed over, the beats a writeback
// should produce are the 64-bit slices of the line it offered, and latency is
// 5 cycles plus one per stall cycle.

module tb_cacheline_adaptor;

  logic         clk;
  logic         rst;
  logic [255:0] line_i;
  logic [255:0] line_o;
  logic [31:0]  address_i;
  logic         read_i;
  logic         write_i;
  logic         resp_o;
  logic [63:0]  burst_i;
  logic [63:0]  burst_o;
  logic [31:0]  address_o;
  logic         read_o;
  logic         write_o;
  logic         resp_i;

  int tests = 0;
  int fails = 0;

  logic [255:0] last_line;

  cacheline_adaptor #(.s_line(256), .s_burst(64)) dut (
    .clk       (clk),
    .rst       (rst),
    .line_i    (line_i),
    .line_o    (line_o),
    .address_i (address_i),
    .read_i    (read_i),
    .write_i   (write_i),
    .resp_o    (resp_o),
    .burst_i   (burst_i),
    .burst_o   (burst_o),
    .address_o (address_o),
    .read_o    (read_o),
    .write_o   (write_o),
    .resp_i    (resp_i)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [255:0] got, input logic [255:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [63:0] rand64();
    return {$urandom, $urandom};
  endfunction

  function automatic logic [255:0] rand256();
    return {rand64(), rand64(), rand64(), rand64()};
  endfunction

  // Line read. pat_len>0 drives resp_i from pat bits (LSB first) during the
  // burst; otherwise stalls are random. directed uses beats 0x11..,0x22..,...
  task automatic do_read(input logic [31:0] addr, input int unsigned pat,
                         input int pat_len, input bit directed);
    logic [255:0] exp;
    logic [63:0]  beat;
    logic [31:0]  exp_addr;
    int           k, stalls, cyc, rd_cycles, pi;
    bit           done, go;
    exp = '0; k = 0; stalls = 0; cyc = 0; rd_cycles = 0; pi = 0; done = 0;
    exp_addr  = addr & 32'hFFFF_FFE0;
    address_i = addr;
    read_i    = 1'b1;
    write_i   = 1'b0;
    resp_i    = 1'b0;
    while (!done && cyc < 200) begin
      @(negedge clk);
      cyc++;
      if (resp_o) begin
        done = 1;
      end else begin
        check("rd_write_o_low", write_o, 1'b0);
        // Request and address are latched at accept; wiggle them afterwards.
        if (cyc > 1) address_i = $urandom;
        if (read_o) begin
          rd_cycles++;
          check("rd_address_o", address_o, exp_addr);
          if (pat_len > 0) go = (pi < pat_len && pi < 32) ? pat[pi] : 1'b0;
          else             go = ($urandom_range(0, 2) != 0);
          pi++;
          if (go && k < 4) begin
            beat    = directed ? 64'h1111_1111_1111_1111 * 64'(k + 1) : rand64();
            burst_i = beat;
            resp_i  = 1'b1;
            exp     = exp | (256'(beat) << (64 * k));
            k++;
          end else begin
            burst_i = rand64();
            resp_i  = 1'b0;
            stalls++;
          end
        end else begin
          burst_i = rand64();
          resp_i  = 1'b0;
        end
      end
    end
    check("rd_done", done, 1'b1);
    check("rd_beats", k, 4);
    check("rd_latency", cyc, 5 + stalls);
    check("rd_read_o_cycles", rd_cycles, 4 + stalls);
    check("rd_line_o", line_o, exp);
    // Upstream drops the request at the edge after resp_o; resp_i is noise.
    read_i  = 1'b0;
    resp_i  = $urandom_range(0, 1);
    burst_i = rand64();
    @(negedge clk);
    check("rd_resp_single", resp_o, 1'b0);
    check("rd_idle_read_o", read_o, 1'b0);
    check("rd_line_hold", line_o, exp);
    resp_i = 1'b0;
    last_line = exp;
    $display("[TB] read  addr=%h stalls=%0d line=%h", addr, stalls, line_o);
  endtask

  // Line writeback; with both=1 read_i is raised too and must be ignored.
  task automatic do_write(input logic [31:0] addr, input logic [255:0] line,
                          input bit both, input bit nostall);
    logic [31:0] exp_addr;
    int          k, stalls, cyc, wr_cycles;
    bit          done, go;
    k = 0; stalls = 0; cyc = 0; wr_cycles = 0; done = 0;
    exp_addr  = addr & 32'hFFFF_FFE0;
    address_i = addr;
    line_i    = line;
    write_i   = 1'b1;
    read_i    = both;
    resp_i    = 1'b0;
    while (!done && cyc < 200) begin
      @(negedge clk);
      cyc++;
      if (resp_o) begin
        done = 1;
      end else begin
        check("wr_read_o_low", read_o, 1'b0);
        if (cyc > 1) begin
          address_i = $urandom;
          line_i    = rand256();
        end
        if (write_o) begin
          wr_cycles++;
          check("wr_address_o", address_o, exp_addr);
          if (k < 4) check("wr_burst_o", burst_o, 64'(line >> (64 * k)));
          go = nostall ? 1'b1 : ($urandom_range(0, 2) != 0);
          if (go && k < 4) begin
            resp_i = 1'b1;
            k++;
          end else begin
            resp_i = 1'b0;
            stalls++;
          end
        end else begin
          resp_i = 1'b0;
        end
      end
    end
    check("wr_done", done, 1'b1);
    check("wr_beats", k, 4);
    check("wr_latency", cyc, 5 + stalls);
    check("wr_write_o_cycles", wr_cycles, 4 + stalls);
    check("wr_line_o_untouched", line_o, last_line);
    write_i = 1'b0;
    read_i  = 1'b0;
    resp_i  = $urandom_range(0, 1);
    @(negedge clk);
    check("wr_resp_single", resp_o, 1'b0);
    check("wr_idle_write_o", write_o, 1'b0);
    resp_i = 1'b0;
    $display("[TB] write addr=%h stalls=%0d both=%0d", addr, stalls, both);
  endtask

  initial begin
    rst       = 1'b1;
    line_i    = '0;
    address_i = '0;
    read_i    = 1'b0;
    write_i   = 1'b0;
    burst_i   = '0;
    resp_i    = 1'b0;
    last_line = '0;

    repeat (2) @(negedge clk);
    check("rst_line_o", line_o, '0);
    check("rst_address_o", address_o, '0);
    check("rst_burst_o", burst_o, '0);
    check("rst_ctrl", {read_o, write_o, resp_o}, 3'b000);
    rst = 1'b0;
    @(negedge clk);
    check("idle_ctrl", {read_o, write_o, resp_o}, 3'b000);

    // Directed cases from the plan.
    do_read(32'h0000_1234, 32'hF, 4, 1'b1);
    check("dir_line", line_o, {64'h4444_4444_4444_4444, 64'h3333_3333_3333_3333,
                               64'h2222_2222_2222_2222, 64'h1111_1111_1111_1111});
    do_write(32'h0000_8765, rand256(), 1'b0, 1'b1);
    do_read(32'hDEAD_BEEF, 32'h59, 7, 1'b0);
    do_write(32'h1234_5678, rand256(), 1'b1, 1'b1);

    // Randomized mix.
    for (int i = 0; i < 12; i++) begin
      if ($urandom_range(0, 1) != 0) do_read($urandom, 0, 0, 1'b0);
      else do_write($urandom, rand256(), $urandom_range(0, 1) != 0, 1'b0);
    end

    // Reset after two read beats.
    address_i = 32'h0000_4444;
    read_i    = 1'b1;
    @(negedge clk);
    burst_i = rand64(); resp_i = 1'b1;
    @(negedge clk);
    burst_i = rand64(); resp_i = 1'b1;
    @(negedge clk);
    resp_i = 1'b0;
    #2 rst = 1'b1;
    #1;
    check("mid_rst_line_o", line_o, '0);
    check("mid_rst_address_o", address_o, '0);
    check("mid_rst_ctrl", {read_o, write_o, resp_o}, 3'b000);
    read_i = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    last_line = '0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("post_rst_ctrl", {read_o, write_o, resp_o}, 3'b000);
    end
    do_read(32'h0000_4444, 0, 0, 1'b0);

    // Writeback immediately followed by refill, then nothing more.
    do_write(32'h0000_2000, rand256(), 1'b0, 1'b0);
    do_read(32'h0000_3000, 0, 0, 1'b0);
    for (int i = 0; i < 8; i++) begin
      resp_i = $urandom_range(0, 1);
      @(negedge clk);
      check("no_third_burst", {read_o, write_o, resp_o}, 3'b000);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
